// File: rtl/dragonfang_pkg.sv
// Shared types for the dragonfang vector datapath.
// execution_vector_t names the compare operation and its element width.
package dragonfang_pkg;

    typedef enum logic [5:0] {
        VOP_NONE  = 6'd0,
        vmseq_8   = 6'd1,
        vmsne_8   = 6'd2,
        vmsltu_8  = 6'd3,
        vmslt_16  = 6'd4,
        vmsle_16  = 6'd5,
        vmsltu_32 = 6'd6,
        vmsgt_64  = 6'd7
    } execution_vector_t;

endpackage

// File: rtl/vector_comparison_sequencer.sv
// Walks a vector compare 64 bits per cycle through vector_comparison_unit and assembles the mask.
// Latency NS+1 (NS+2 with DRAGONFANG_VCMP_OPERAND_REG_EN); holds done_valid until done_ready.
module vector_comparison_sequencer
    import dragonfang_pkg::*;
#(
    parameter int VLEN = 512
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic                                       start_valid,
    output logic                                       start_ready,
    input  execution_vector_t                          execution_vector_in,
    input  logic [1:0]                                 sew,
    input  logic [$clog2(VLEN/8):0]                    vl,
    output logic [((VLEN > 64) ? $clog2(VLEN/64) : 1)-1:0] slice_index,
    input  logic [63:0]                                vs2_slice,
    input  logic [63:0]                                vs1_slice,
    output execution_vector_t                          cu_execution_vector,
    output logic [63:0]                                cu_vs2,
    output logic [63:0]                                cu_vs1,
    input  logic [7:0]                                 cu_vd,
    output logic [VLEN/8-1:0]                          mask_result,
    output logic                                       done_valid,
    input  logic                                       done_ready,
    output logic                                       busy
);

    localparam int MW  = VLEN / 8;
    localparam int MIW = $clog2(MW);
    localparam int VLW = $clog2(MW) + 1;
    localparam int SW  = (VLEN > 64) ? $clog2(VLEN/64) : 1;
    localparam int CW  = $clog2(VLEN/64) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    execution_vector_t ev_q, ev_d;
    logic [1:0]        sew_q, sew_d;
    logic [VLW-1:0]    vl_q, vl_d;
    logic [CW-1:0]     ns_q, ns_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [MW-1:0]     mask_q, mask_d;

    logic              accept;
    logic              issue;
    logic              last;
    logic              wr_en;
    logic [CW-1:0]     wr_idx;
    logic [3:0]        eps_q;
    logic [3:0]        eps_in;
    logic [VLW-1:0]    vlmax;
    logic [VLW-1:0]    vl_clamp;
    logic [VLW:0]      ns_w;
    logic [31:0]       bit_idx;

    assign eps_in   = 4'd8 >> sew;
    assign eps_q    = 4'd8 >> sew_q;
    assign vlmax    = VLW'(MW >> sew);
    assign vl_clamp = (vl > vlmax) ? vlmax : vl;
    assign ns_w     = ({1'b0, vl_clamp} + (VLW+1)'(eps_in - 4'd1)) >> (2'd3 - sew);

`ifdef DRAGONFANG_VCMP_OPERAND_REG_EN
    // Operands are registered, so each cu_vd belongs to the slice issued one cycle earlier;
    // the counter runs one step past NS to drain that final capture.
    logic          pend_vld_q;
    logic [CW-1:0] pend_cnt_q;
    logic [63:0]   cu_vs2_q, cu_vs1_q;

    assign issue  = (state_q == S_RUN) && (cnt_q < ns_q);
    assign last   = (cnt_q == ns_q);
    assign wr_en  = pend_vld_q;
    assign wr_idx = pend_cnt_q;
    assign cu_vs2 = cu_vs2_q;
    assign cu_vs1 = cu_vs1_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld_q <= 1'b0;
            pend_cnt_q <= '0;
            cu_vs2_q   <= '0;
            cu_vs1_q   <= '0;
        end else begin
            pend_vld_q <= issue;
            pend_cnt_q <= cnt_q;
            cu_vs2_q   <= issue ? vs2_slice : 64'd0;
            cu_vs1_q   <= issue ? vs1_slice : 64'd0;
        end
    end
`else
    assign issue  = (state_q == S_RUN);
    assign last   = (cnt_q == ns_q - 1'b1);
    assign wr_en  = issue;
    assign wr_idx = cnt_q;
    assign cu_vs2 = issue ? vs2_slice : 64'd0;
    assign cu_vs1 = issue ? vs1_slice : 64'd0;
`endif

    assign start_ready         = (state_q == S_IDLE);
    assign busy                = (state_q != S_IDLE);
    assign done_valid          = (state_q == S_DONE);
    assign slice_index         = issue ? SW'(cnt_q) : '0;
    assign cu_execution_vector = busy ? ev_q : VOP_NONE;
    assign mask_result         = mask_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ev_d    = ev_q;
        sew_d   = sew_q;
        vl_d    = vl_q;
        ns_d    = ns_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    accept  = 1'b1;
                    ev_d    = execution_vector_in;
                    sew_d   = sew;
                    vl_d    = vl_clamp;
                    ns_d    = CW'(ns_w);
                    cnt_d   = '0;
                    state_d = (vl_clamp == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bits at or beyond vl are never written, so the tail stays at the zero set on accept.
    always_comb begin
        mask_d  = mask_q;
        bit_idx = '0;
        if (accept) begin
            mask_d = '0;
        end else if (wr_en) begin
            for (int j = 0; j < 8; j++) begin
                bit_idx = 32'(wr_idx) * 32'(eps_q) + 32'(j);
                if ((4'(j) < eps_q) && (bit_idx < 32'(vl_q))) begin
                    mask_d[bit_idx[MIW-1:0]] = cu_vd[3'(j)];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ev_q    <= VOP_NONE;
            sew_q   <= '0;
            vl_q    <= '0;
            ns_q    <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_d;
            sew_q   <= sew_d;
            vl_q    <= vl_d;
            ns_q    <= ns_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: doc/vector_comparison_sequencer.md
VECTOR_COMPARISON_SEQUENCER -- requirements
Module: vector_comparison_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 512, meaning bits per vector register; legal values are multiples of 64 from 64 to 1024.
REQ-002 SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start_valid, input, 1 bit: a compare request is present.
REQ-005 SHALL have port start_ready, output, 1 bit: the sequencer can accept a request.
REQ-006 SHALL have port execution_vector_in, input, execution_vector_t (from dragonfang_pkg): the compare operation, for example vmslt_16.
REQ-007 SHALL have port sew, input, 2 bits: element width, 00=8, 01=16, 10=32, 11=64.
REQ-008 SHALL have port vl, input, clog2(VLEN/8)+1 bits: element count.
REQ-009 SHALL have port slice_index, output, clog2(VLEN/64) bits: index of the 64-bit operand slice being read.
REQ-010 SHALL have ports vs2_slice and vs1_slice, input, 64 bits each: operand slices returned in the same cycle for slice_index.
REQ-011 SHALL have ports cu_execution_vector (execution_vector_t), cu_vs2 and cu_vs1 (64 bits each), output: drive vector_comparison_unit.
REQ-012 SHALL have port cu_vd, input, 8 bits: mask bits returned by vector_comparison_unit.
REQ-013 SHALL have port mask_result, output, VLEN/8 bits: the assembled destination mask.
REQ-014 SHALL have port done_valid, output, 1 bit: mask_result is complete.
REQ-015 SHALL have port done_ready, input, 1 bit: the consumer accepts the result.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN and DONE; start_ready SHALL be 1 only in IDLE.
REQ-018 SHALL accept a request when start_valid and start_ready are both 1, latching execution_vector_in and sew, latching vl clamped to VLMAX = VLEN/(8<<sew), clearing mask_result and setting the slice counter to 0.
REQ-019 SHALL, on accept, go to DONE if the clamped vl is 0, and otherwise go to RUN.
REQ-020 SHALL use EPS = 8>>sew elements per slice and NS = ceil(vl/EPS) slices.
REQ-021 SHALL, in each RUN cycle, drive slice_index = counter, pass vs2_slice and vs1_slice to cu_vs2 and cu_vs1, and write cu_vd[EPS-1:0] into mask_result[counter*EPS +: EPS].
REQ-022 SHALL force to 0 every mask bit at index >= vl (tail), even when cu_vd reports 1 for it.
REQ-023 SHALL, after the RUN cycle with counter = NS-1, go to DONE; latency from accept to done_valid is NS+1 cycles.
REQ-024 SHALL, in DONE, hold done_valid = 1 and keep mask_result stable until done_ready = 1, then go to IDLE; mask_result SHALL hold until the next accept.
REQ-025 SHALL hold cu_execution_vector at the latched value while busy, and at '0 in IDLE.
REQ-026 SHALL ignore start_valid while busy; no request is queued.

Reset
REQ-027 SHALL, while reset_n = 0 at any time including mid-RUN, immediately force state IDLE, counter 0, mask_result 0, done_valid 0, busy 0, start_ready 1, slice_index 0, cu_* outputs 0.

Configuration
REQ-028 SHALL, with DRAGONFANG_VCMP_OPERAND_REG_EN defined, register cu_vs2 and cu_vs1 for one cycle, align the cu_vd capture one cycle later and add one drain cycle, so latency is NS+2 cycles.
REQ-029 SHALL, without DRAGONFANG_VCMP_OPERAND_REG_EN, use the combinational pass-through, so latency is NS+1 cycles.

Verification
REQ-030 Reset: reset_n=0 -> start_ready=1, busy=0, done_valid=0, mask_result=0.
REQ-031 vmseq_8, vl=64, VLEN=512, vs2_slice==vs1_slice for all slices -> 8 RUN cycles with slice_index 0..7, done_valid after 9 cycles, mask_result=64'hFFFF_FFFF_FFFF_FFFF.
REQ-032 vmsltu_32, vl=5, vs2<vs1 in every element -> 3 slices, mask_result=64'h1F (bit 5 zeroed as tail).
REQ-033 vl=0 -> done_valid=1 one cycle after accept, mask_result=0, no RUN cycles.
REQ-034 vmsgt_64, vl=20 (clamped to 8), all element compares true -> 8 slices, mask_result=64'hFF.
REQ-035 done_ready held 0 for 3 cycles -> done_valid and mask_result stable, start_valid ignored; reset_n pulsed low during RUN -> IDLE and mask_result=0 at once.
